// File: rtl/reg_file_pkg.sv
// reg_file_pkg
// Shared definitions for the register-file write path.
//   REG_FILE_W / REG_FILE_A / REG_FILE_DEPTH : default data width, address
//                                              width and queue depth
//   reg_file_entry_t                         : one queued write {addr, data}
//                                              at the default geometry
//   clog2()                                  : ceiling log2 for sizing
//                                              pointers and counters
package reg_file_pkg;

    localparam int REG_FILE_W     = 8;
    localparam int REG_FILE_A     = 3;
    localparam int REG_FILE_DEPTH = 4;

    typedef struct packed {
        logic [REG_FILE_A-1:0] addr;
        logic [REG_FILE_W-1:0] data;
    } reg_file_entry_t;

    // Smallest r with 2**r >= value; clog2(1) is 0.
    function automatic int clog2(input int value);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) begin
                r = i + 1;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/reg_file_addr_decoder.sv
// reg_file_addr_decoder
// Combinational A-to-2**A one-hot decoder with enable.
// Ports:
//   addr   in  A       register index to decode
//   en     in  1       when low the output is all-zero
//   onehot out 2**A    one bit set at position addr when enabled
module reg_file_addr_decoder #(
    parameter int A = 3
) (
    input  logic [A-1:0]    addr,
    input  logic            en,
    output logic [2**A-1:0] onehot
);

    always_comb begin
        onehot = '0;
        if (en) begin
            onehot[addr] = 1'b1;
        end
    end

endmodule

// File: rtl/reg_file_write_queue.sv
// reg_file_write_queue
// Write-port front end for the register file. Requests {addr, data} arrive
// over a valid/ready handshake, are buffered in a DEPTH-entry FIFO and drain
// one per cycle as a registered one-hot write_enable with shared data.
//
// Optional feature macro: REG_FILE_WRITE_QUEUE_BYPASS_EN
//   When defined, a request arriving while the queue is empty and the bank is
//   not held is loaded straight into the output registers, saving one cycle.
//
// Ports:
//   clk                  in  1            clock, rising edge
//   reset_synchronous_n  in  1            synchronous active-low reset
//   wr_valid             in  1            request present
//   wr_ready             out 1            queue not full
//   wr_addr              in  A            target register index
//   wr_data              in  W            value to write
//   rf_hold              in  1            bank busy, suppresses draining
//   out_write_enable     out 2**A         registered one-hot write enable
//   out_addr             out A            index of the current write
//   out_data             out W            data of the current write
//   count                out clog2(DEPTH)+1  occupied entries
module reg_file_write_queue
    import reg_file_pkg::*;
#(
    parameter int W     = REG_FILE_W,
    parameter int A     = REG_FILE_A,
    parameter int DEPTH = REG_FILE_DEPTH
) (
    input  logic                   clk,
    input  logic                   reset_synchronous_n,
    input  logic                   wr_valid,
    output logic                   wr_ready,
    input  logic [A-1:0]           wr_addr,
    input  logic [W-1:0]           wr_data,
    input  logic                   rf_hold,
    output logic [2**A-1:0]        out_write_enable,
    output logic [A-1:0]           out_addr,
    output logic [W-1:0]           out_data,
    output logic [clog2(DEPTH):0]  count
);

    localparam int PW = clog2(DEPTH);
    localparam int CW = PW + 1;

    // Entry layout at this instance's geometry; matches reg_file_entry_t at
    // the default parameters.
    typedef struct packed {
        logic [A-1:0] addr;
        logic [W-1:0] data;
    } entry_t;

    entry_t          mem [DEPTH];
    logic [PW-1:0]   rd_ptr;
    logic [PW-1:0]   wr_ptr;
    entry_t          head;

    logic            push_req;
    logic            bypass;
    logic            push_fifo;
    logic            pop;
    logic            load;
    logic [A-1:0]    dec_addr;
    logic [W-1:0]    dec_data;
    logic [2**A-1:0] dec_onehot;

    // Ready depends on occupancy only, so a full queue cannot take a push
    // in the same cycle it pops.
    assign wr_ready = (count != CW'(DEPTH));
    assign push_req = wr_valid && wr_ready;
    assign pop      = (count != '0) && !rf_hold;
    assign head     = mem[rd_ptr];

`ifdef REG_FILE_WRITE_QUEUE_BYPASS_EN
    // An empty, unheld queue forwards the request straight to the outputs.
    assign bypass = push_req && (count == '0) && !rf_hold;
`else
    assign bypass = 1'b0;
`endif

    // Bypass and pop are exclusive: bypass needs an empty queue, pop a
    // non-empty one.
    assign push_fifo = push_req && !bypass;
    assign load      = pop || bypass;
    assign dec_addr  = bypass ? wr_addr : head.addr;
    assign dec_data  = bypass ? wr_data : head.data;

    reg_file_addr_decoder #(
        .A (A)
    ) u_addr_decoder (
        .addr   (dec_addr),
        .en     (load),
        .onehot (dec_onehot)
    );

    // Storage has no reset; clearing the pointers discards its contents.
    always_ff @(posedge clk) begin
        if (reset_synchronous_n && push_fifo) begin
            mem[wr_ptr] <= '{addr: wr_addr, data: wr_data};
        end
    end

    // Pointers, occupancy and the registered write port. Pointers wrap
    // naturally because DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (!reset_synchronous_n) begin
            rd_ptr           <= '0;
            wr_ptr           <= '0;
            count            <= '0;
            out_write_enable <= '0;
            out_addr         <= '0;
            out_data         <= '0;
        end else begin
            if (push_fifo) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            case ({push_fifo, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
            // Enable is zero on idle cycles; addr/data keep the last write.
            out_write_enable <= dec_onehot;
            if (load) begin
                out_addr <= dec_addr;
                out_data <= dec_data;
            end
        end
    end

endmodule

// File: tb/tb_reg_file_write_queue.sv
// tb_reg_file_write_queue
// Directed self-checking bench for reg_file_write_queue at the default
// geometry (W=8, A=3, DEPTH=4). Latency expectations follow the
// REG_FILE_WRITE_QUEUE_BYPASS_EN setting of the build.
module tb_reg_file_write_queue;
    import reg_file_pkg::*;

`ifdef REG_FILE_WRITE_QUEUE_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic       clk;
    logic       reset_synchronous_n;
    logic       wr_valid;
    logic       wr_ready;
    logic [2:0] wr_addr;
    logic [7:0] wr_data;
    logic       rf_hold;
    logic [7:0] out_write_enable;
    logic [2:0] out_addr;
    logic [7:0] out_data;
    logic [2:0] count;

    int checks;
    int fails;

    reg_file_write_queue #(
        .W     (8),
        .A     (3),
        .DEPTH (4)
    ) dut (
        .clk                 (clk),
        .reset_synchronous_n (reset_synchronous_n),
        .wr_valid            (wr_valid),
        .wr_ready            (wr_ready),
        .wr_addr             (wr_addr),
        .wr_data             (wr_data),
        .rf_hold             (rf_hold),
        .out_write_enable    (out_write_enable),
        .out_addr            (out_addr),
        .out_data            (out_data),
        .count               (count)
    );

    // 10-unit clock, rising edges at 5, 15, 25, ...
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one rising edge and settle; outputs are read and inputs
    // re-driven 1 unit after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset_synchronous_n = 1'b0;
        tick();
        tick();
        reset_synchronous_n = 1'b1;
        checks++;
        if (count !== 3'd0) begin
            fails++;
            $display("[TB] FAIL reset_count: got %0d expected 0", count);
        end
        checks++;
        if (out_write_enable !== 8'h00 || out_addr !== 3'd0 || out_data !== 8'h00) begin
            fails++;
            $display("[TB] FAIL reset_outputs: got we=%h addr=%0d data=%h expected 00/0/00",
                     out_write_enable, out_addr, out_data);
        end
        checks++;
        if (wr_ready !== 1'b1) begin
            fails++;
            $display("[TB] FAIL reset_ready: got %b expected 1", wr_ready);
        end
        // Queue three held entries, then reset with a request still offered.
        rf_hold  = 1'b1;
        wr_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            wr_addr = 3'(i + 1);
            wr_data = 8'(8'h70 + i);
            tick();
        end
        checks++;
        if (count !== 3'd3) begin
            fails++;
            $display("[TB] FAIL reset_prefill_count: got %0d expected 3", count);
        end
        rf_hold             = 1'b0;
        reset_synchronous_n = 1'b0;
        tick();
        wr_valid            = 1'b0;
        reset_synchronous_n = 1'b1;
        checks++;
        if (count !== 3'd0 || wr_ready !== 1'b1 || out_write_enable !== 8'h00) begin
            fails++;
            $display("[TB] FAIL reset_midburst: got count=%0d ready=%b we=%h expected 0/1/00",
                     count, wr_ready, out_write_enable);
        end
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if (out_write_enable !== 8'h00 || count !== 3'd0) begin
                fails++;
                $display("[TB] FAIL reset_no_stale: got we=%h count=%0d expected 00/0",
                         out_write_enable, count);
            end
        end
    endtask

    task automatic test_single();
        int hit;
        logic [7:0] exp_we;
        hit      = BYP ? 0 : 1;
        rf_hold  = 1'b0;
        wr_valid = 1'b1;
        wr_addr  = 3'd5;
        wr_data  = 8'hA5;
        for (int i = 0; i < 3; i++) begin
            tick();
            wr_valid = 1'b0;
            exp_we = (i == hit) ? 8'b0010_0000 : 8'h00;
            checks++;
            if (out_write_enable !== exp_we) begin
                fails++;
                $display("[TB] FAIL single_we cycle %0d: got %h expected %h",
                         i, out_write_enable, exp_we);
            end
            if (i == hit) begin
                checks++;
                if (out_data !== 8'hA5 || out_addr !== 3'd5) begin
                    fails++;
                    $display("[TB] FAIL single_data: got addr=%0d data=%h expected 5/a5",
                             out_addr, out_data);
                end
            end
            if (i == 0) begin
                checks++;
                if (count !== (BYP ? 3'd0 : 3'd1)) begin
                    fails++;
                    $display("[TB] FAIL single_count: got %0d expected %0d",
                             count, BYP ? 0 : 1);
                end
            end
        end
    endtask

    task automatic test_full();
        reg_file_entry_t exp_q [4];
        exp_q[0] = '{addr: 3'd1, data: 8'h10};
        exp_q[1] = '{addr: 3'd3, data: 8'h31};
        exp_q[2] = '{addr: 3'd6, data: 8'h62};
        exp_q[3] = '{addr: 3'd0, data: 8'h03};
        rf_hold  = 1'b1;
        wr_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            wr_addr = exp_q[i].addr;
            wr_data = exp_q[i].data;
            tick();
            checks++;
            if (count !== 3'(i + 1)) begin
                fails++;
                $display("[TB] FAIL full_fill_count: got %0d expected %0d", count, i + 1);
            end
        end
        checks++;
        if (wr_ready !== 1'b0) begin
            fails++;
            $display("[TB] FAIL full_ready: got %b expected 0", wr_ready);
        end
        // A fifth request is refused while held, and also at the release
        // edge, because a full queue cannot push while it pops.
        wr_addr = 3'd7;
        wr_data = 8'hFF;
        tick();
        tick();
        checks++;
        if (count !== 3'd4 || out_write_enable !== 8'h00) begin
            fails++;
            $display("[TB] FAIL full_fifth_refused: got count=%0d we=%h expected 4/00",
                     count, out_write_enable);
        end
        rf_hold = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            wr_valid = 1'b0;
            checks++;
            if (out_write_enable !== (8'h01 << exp_q[i].addr) || out_data !== exp_q[i].data) begin
                fails++;
                $display("[TB] FAIL full_drain %0d: got we=%h data=%h expected %h/%h",
                         i, out_write_enable, out_data, 8'h01 << exp_q[i].addr, exp_q[i].data);
            end
            if (i == 0) begin
                checks++;
                if (count !== 3'd3) begin
                    fails++;
                    $display("[TB] FAIL full_pop_no_push: got count=%0d expected 3", count);
                end
            end
        end
        tick();
        checks++;
        if (out_write_enable !== 8'h00 || count !== 3'd0) begin
            fails++;
            $display("[TB] FAIL full_idle: got we=%h count=%0d expected 00/0",
                     out_write_enable, count);
        end
    endtask

    task automatic test_back_to_back();
        int w;
        logic [7:0] exp_we;
        logic [2:0] exp_count;
        rf_hold = 1'b0;
        for (int k = 0; k <= 10; k++) begin
            wr_valid = (k < 10);
            wr_addr  = 3'(k % 8);
            wr_data  = 8'(8'hC0 + k);
            tick();
            w = BYP ? k : k - 1;
            exp_we    = (w >= 0 && w < 10) ? (8'h01 << (w % 8)) : 8'h00;
            exp_count = (!BYP && k < 10) ? 3'd1 : 3'd0;
            checks++;
            if (out_write_enable !== exp_we || count !== exp_count) begin
                fails++;
                $display("[TB] FAIL b2b cycle %0d: got we=%h count=%0d expected %h/%0d",
                         k, out_write_enable, count, exp_we, exp_count);
            end
            if (exp_we != 8'h00) begin
                checks++;
                if (out_data !== 8'(8'hC0 + w)) begin
                    fails++;
                    $display("[TB] FAIL b2b_data cycle %0d: got %h expected %h",
                             k, out_data, 8'(8'hC0 + w));
                end
            end
        end
        wr_valid = 1'b0;
        tick();
        checks++;
        if (out_write_enable !== 8'h00 || count !== 3'd0) begin
            fails++;
            $display("[TB] FAIL b2b_idle: got we=%h count=%0d expected 00/0",
                     out_write_enable, count);
        end
    endtask

    task automatic test_hold_toggle();
        int next;
        logic [7:0] exp_we;
        rf_hold  = 1'b1;
        wr_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            wr_addr = 3'(4 + i);
            wr_data = 8'(8'h40 + i);
            tick();
        end
        wr_valid = 1'b0;
        checks++;
        if (count !== 3'd4) begin
            fails++;
            $display("[TB] FAIL hold_fill_count: got %0d expected 4", count);
        end
        next = 0;
        for (int j = 0; j < 8; j++) begin
            rf_hold = (j % 2 == 1);
            tick();
            if (!rf_hold && next < 4) begin
                exp_we = 8'h01 << (4 + next);
                next++;
            end else begin
                exp_we = 8'h00;
            end
            checks++;
            if (out_write_enable !== exp_we) begin
                fails++;
                $display("[TB] FAIL hold_toggle_we edge %0d: got %h expected %h",
                         j, out_write_enable, exp_we);
            end
            if (exp_we != 8'h00) begin
                checks++;
                if (out_data !== 8'(8'h40 + next - 1)) begin
                    fails++;
                    $display("[TB] FAIL hold_toggle_data edge %0d: got %h expected %h",
                             j, out_data, 8'(8'h40 + next - 1));
                end
            end
        end
        rf_hold = 1'b0;
        checks++;
        if (count !== 3'd0) begin
            fails++;
            $display("[TB] FAIL hold_toggle_count: got %0d expected 0", count);
        end
    endtask

    task automatic test_same_addr();
        logic [7:0] bank [8];
        logic [7:0] seen [2];
        int nwrites;
        for (int i = 0; i < 8; i++) bank[i] = 8'h00;
        nwrites  = 0;
        rf_hold  = 1'b0;
        wr_valid = 1'b1;
        for (int k = 0; k < 5; k++) begin
            wr_addr = 3'd2;
            wr_data = (k == 0) ? 8'h11 : 8'h22;
            if (k >= 2) wr_valid = 1'b0;
            tick();
            if (out_write_enable != 8'h00) begin
                checks++;
                if (out_write_enable !== 8'h04) begin
                    fails++;
                    $display("[TB] FAIL same_addr_we: got %h expected 04", out_write_enable);
                end
                if (nwrites < 2) seen[nwrites] = out_data;
                nwrites++;
                bank[out_addr] = out_data;
            end
        end
        checks++;
        if (nwrites !== 2) begin
            fails++;
            $display("[TB] FAIL same_addr_count: got %0d writes expected 2", nwrites);
        end else begin
            checks++;
            if (seen[0] !== 8'h11 || seen[1] !== 8'h22) begin
                fails++;
                $display("[TB] FAIL same_addr_order: got %h,%h expected 11,22", seen[0], seen[1]);
            end
        end
        checks++;
        if (bank[2] !== 8'h22) begin
            fails++;
            $display("[TB] FAIL same_addr_final: got %h expected 22", bank[2]);
        end
    endtask

    initial begin
        checks              = 0;
        fails               = 0;
        reset_synchronous_n = 1'b0;
        wr_valid            = 1'b0;
        wr_addr             = 3'd0;
        wr_data             = 8'h00;
        rf_hold             = 1'b0;
        $display("[TB] bypass build = %0d", BYP);
        test_reset();
        test_single();
        test_full();
        test_back_to_back();
        test_hold_toggle();
        test_same_addr();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

    // Guard against a hung run.
    initial begin
        #100000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
